// File: rtl/brq_fp_regfile_sb.sv
// Buraq FP register file: 32 x FLEN registers, two prioritised write ports,
// a per-register busy scoreboard, NaN-boxing, optional write bypass and FS dirty tracking.
module brq_fp_regfile_sb #(
  parameter int unsigned FLEN         = 32,
  parameter int unsigned NumReadPorts = 3,
  parameter bit          BypassEn     = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumReadPorts-1:0][4:0]         raddr_i,
  output logic [NumReadPorts-1:0][FLEN-1:0]    rdata_o,
  output logic [NumReadPorts-1:0]              rbusy_o,
  input  logic                                 alloc_i,
  input  logic [4:0]                           alloc_addr_i,
  input  logic                                 we_a_i,
  input  logic [4:0]                           waddr_a_i,
  input  logic [FLEN-1:0]                      wdata_a_i,
  input  logic                                 wsingle_a_i,
  input  logic                                 we_b_i,
  input  logic [4:0]                           waddr_b_i,
  input  logic [FLEN-1:0]                      wdata_b_i,
  input  logic                                 wsingle_b_i,
  output logic                                 ready_b_o,
  input  logic                                 fs_clean_i,
  output logic                                 fs_dirty_o
);

  localparam int unsigned NumRegs = 32;

  logic [FLEN-1:0]    r_regs [NumRegs];
  logic [NumRegs-1:0] r_busy;

  logic [FLEN-1:0]    w_fmt_a;
  logic [FLEN-1:0]    w_fmt_b;
  logic               w_commit_a;
  logic               w_commit_b;
  logic [NumRegs-1:0] w_busy_nxt;

  // Single-precision results are NaN-boxed only in double-precision builds.
  if (FLEN == 64) begin : g_box
    assign w_fmt_a = wsingle_a_i ? {32'hFFFF_FFFF, wdata_a_i[31:0]} : wdata_a_i;
    assign w_fmt_b = wsingle_b_i ? {32'hFFFF_FFFF, wdata_b_i[31:0]} : wdata_b_i;
  end else begin : g_nobox
    logic w_unused;
    assign w_unused = wsingle_a_i ^ wsingle_b_i;
    assign w_fmt_a  = wdata_a_i;
    assign w_fmt_b  = wdata_b_i;
  end

  // Port A wins an address collision; the LSU retries port B.
  assign ready_b_o  = !(we_a_i && (waddr_a_i == waddr_b_i));
  assign w_commit_a = we_a_i;
  assign w_commit_b = we_b_i && ready_b_o;

  // Allocation is applied last: it belongs to the younger instruction.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_commit_a) w_busy_nxt[waddr_a_i] = 1'b0;
    if (w_commit_b) w_busy_nxt[waddr_b_i] = 1'b0;
    if (alloc_i)    w_busy_nxt[alloc_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) r_regs[i] <= '0;
      r_busy     <= '0;
      fs_dirty_o <= 1'b0;
    end else begin
      if (w_commit_b) r_regs[waddr_b_i] <= w_fmt_b;
      if (w_commit_a) r_regs[waddr_a_i] <= w_fmt_a;
      r_busy <= w_busy_nxt;
      if (w_commit_a || w_commit_b) fs_dirty_o <= 1'b1;
      else if (fs_clean_i)          fs_dirty_o <= 1'b0;
    end
  end

  // Read ports, with same-cycle forwarding when bypass is enabled.
  always_comb begin
    for (int k = 0; k < NumReadPorts; k++) begin
      rdata_o[k] = r_regs[raddr_i[k]];
      rbusy_o[k] = r_busy[raddr_i[k]];
      if (BypassEn) begin
        if (w_commit_a && (waddr_a_i == raddr_i[k])) begin
          rdata_o[k] = w_fmt_a;
          rbusy_o[k] = 1'b0;
        end else if (w_commit_b && (waddr_b_i == raddr_i[k])) begin
          rdata_o[k] = w_fmt_b;
          rbusy_o[k] = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_brq_fp_regfile_sb.sv
// Bench for brq_fp_regfile_sb: FLEN=64 with and without bypass, directed cases
// followed by random traffic checked against an array-based reference model.
module tb_brq_fp_regfile_sb;

  localparam int unsigned FLEN = 64;
  localparam int unsigned NRP  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n;
  logic [NRP-1:0][4:0]       raddr;
  logic                      alloc;
  logic [4:0]                alloc_addr;
  logic                      we_a, we_b, ws_a, ws_b, fs_clean;
  logic [4:0]                wa_a, wa_b;
  logic [FLEN-1:0]           wd_a, wd_b;

  logic [NRP-1:0][FLEN-1:0]  rdata_byp, rdata_nob;
  logic [NRP-1:0]            rbusy_byp, rbusy_nob;
  logic                      ready_byp, ready_nob, dirty_byp, dirty_nob;

  logic [FLEN-1:0] m_reg [32];
  logic            m_busy [32];
  logic            m_dirty;
  int              n_total = 0;
  int              n_bad   = 0;

  brq_fp_regfile_sb #(.FLEN(FLEN), .NumReadPorts(NRP), .BypassEn(1'b1)) u_dut_byp (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_byp), .rbusy_o(rbusy_byp),
    .alloc_i(alloc), .alloc_addr_i(alloc_addr),
    .we_a_i(we_a), .waddr_a_i(wa_a), .wdata_a_i(wd_a), .wsingle_a_i(ws_a),
    .we_b_i(we_b), .waddr_b_i(wa_b), .wdata_b_i(wd_b), .wsingle_b_i(ws_b),
    .ready_b_o(ready_byp), .fs_clean_i(fs_clean), .fs_dirty_o(dirty_byp));

  brq_fp_regfile_sb #(.FLEN(FLEN), .NumReadPorts(NRP), .BypassEn(1'b0)) u_dut_nob (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_nob), .rbusy_o(rbusy_nob),
    .alloc_i(alloc), .alloc_addr_i(alloc_addr),
    .we_a_i(we_a), .waddr_a_i(wa_a), .wdata_a_i(wd_a), .wsingle_a_i(ws_a),
    .we_b_i(we_b), .waddr_b_i(wa_b), .wdata_b_i(wd_b), .wsingle_b_i(ws_b),
    .ready_b_o(ready_nob), .fs_clean_i(fs_clean), .fs_dirty_o(dirty_nob));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] nan_box(input logic [63:0] d, input logic s);
    return s ? {32'hFFFF_FFFF, d[31:0]} : d;
  endfunction

  task automatic set_idle();
    alloc = 1'b0; alloc_addr = '0; fs_clean = 1'b0;
    we_a = 1'b0; wa_a = '0; wd_a = '0; ws_a = 1'b0;
    we_b = 1'b0; wa_b = '0; wd_b = '0; ws_b = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_dirty = 1'b0;
  endtask

  // Expected outputs from the model state plus the current write inputs.
  task automatic compare_outputs();
    logic rdy, ca, cb, eb;
    logic [63:0] ed;
    rdy = !(we_a && wa_a == wa_b);
    ca  = we_a;
    cb  = we_b && rdy;
    check_eq("ready_b_byp", 64'(ready_byp), 64'(rdy));
    check_eq("ready_b_nob", 64'(ready_nob), 64'(rdy));
    check_eq("fs_dirty_byp", 64'(dirty_byp), 64'(m_dirty));
    check_eq("fs_dirty_nob", 64'(dirty_nob), 64'(m_dirty));
    for (int k = 0; k < NRP; k++) begin
      ed = m_reg[raddr[k]];
      eb = m_busy[raddr[k]];
      check_eq($sformatf("rdata_nob[%0d]", k), rdata_nob[k], ed);
      check_eq($sformatf("rbusy_nob[%0d]", k), 64'(rbusy_nob[k]), 64'(eb));
      if (ca && wa_a == raddr[k]) begin
        ed = nan_box(wd_a, ws_a); eb = 1'b0;
      end else if (cb && wa_b == raddr[k]) begin
        ed = nan_box(wd_b, ws_b); eb = 1'b0;
      end
      check_eq($sformatf("rdata_byp[%0d]", k), rdata_byp[k], ed);
      check_eq($sformatf("rbusy_byp[%0d]", k), 64'(rbusy_byp[k]), 64'(eb));
    end
  endtask

  task automatic model_update();
    logic ca, cb;
    ca = we_a;
    cb = we_b && !(we_a && wa_a == wa_b);
    if (cb) begin m_reg[wa_b] = nan_box(wd_b, ws_b); m_busy[wa_b] = 1'b0; end
    if (ca) begin m_reg[wa_a] = nan_box(wd_a, ws_a); m_busy[wa_a] = 1'b0; end
    if (alloc) m_busy[alloc_addr] = 1'b1;
    if (ca || cb)    m_dirty = 1'b1;
    else if (fs_clean) m_dirty = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    #1 compare_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    #1;
    for (int k = 0; k < NRP; k++) begin
      check_eq($sformatf("rst_rdata[%0d]", k), rdata_byp[k], 64'h0);
      check_eq($sformatf("rst_rbusy[%0d]", k), 64'(rbusy_byp[k]), 64'h0);
      check_eq($sformatf("rst_rbusy_nob[%0d]", k), 64'(rbusy_nob[k]), 64'h0);
    end
    check_eq("rst_dirty", 64'(dirty_byp), 64'h0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    raddr = '0;
    set_idle();
    model_clear();
    @(negedge clk);
    do_reset();

    // Sweep f0..f31 across all ports after reset.
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < NRP; k++) raddr[k] = 5'((i * NRP + k) % 32);
      #1;
      for (int k = 0; k < NRP; k++) check_eq("sweep_zero", rdata_byp[k], 64'h0);
      cycle();
    end

    // NaN-boxed single-precision write to f5.
    raddr = '0;
    we_a = 1'b1; wa_a = 5'd5; wd_a = 64'hDEAD_BEEF_3F80_0000; ws_a = 1'b1; raddr[0] = 5'd5;
    cycle();
    set_idle();
    #1;
    check_eq("box_f5", rdata_nob[0], 64'hFFFF_FFFF_3F80_0000);
    check_eq("box_dirty", 64'(dirty_nob), 64'h1);
    cycle();

    // Collision on f7: A wins, B retries.
    we_a = 1'b1; wa_a = 5'd7; wd_a = 64'h1111;
    we_b = 1'b1; wa_b = 5'd7; wd_b = 64'h2222; raddr[0] = 5'd7;
    #1;
    check_eq("coll_ready", 64'(ready_byp), 64'h0);
    check_eq("coll_byp", rdata_byp[0], 64'h1111);
    cycle();
    set_idle();
    we_b = 1'b1; wa_b = 5'd7; wd_b = 64'h2222;
    #1;
    check_eq("retry_old", rdata_nob[0], 64'h1111);
    check_eq("retry_ready", 64'(ready_byp), 64'h1);
    cycle();
    set_idle();
    #1 check_eq("retry_new", rdata_nob[0], 64'h2222);
    cycle();

    // Allocate f3, write it back via port B three cycles later.
    alloc = 1'b1; alloc_addr = 5'd3; raddr[1] = 5'd3;
    #1 check_eq("alloc_same_cycle", 64'(rbusy_byp[1]), 64'h0);
    cycle();
    set_idle();
    #1 check_eq("alloc_busy", 64'(rbusy_byp[1]), 64'h1);
    cycle();
    cycle();
    we_b = 1'b1; wa_b = 5'd3; wd_b = 64'hABCD;
    #1;
    check_eq("wb_byp_busy", 64'(rbusy_byp[1]), 64'h0);
    check_eq("wb_byp_data", rdata_byp[1], 64'hABCD);
    check_eq("wb_nob_busy", 64'(rbusy_nob[1]), 64'h1);
    cycle();
    set_idle();
    #1;
    check_eq("wb_nob_busy_t4", 64'(rbusy_nob[1]), 64'h0);
    check_eq("wb_nob_data_t4", rdata_nob[1], 64'hABCD);
    cycle();

    // Same-cycle alloc and write of f9: data lands, busy stays.
    alloc = 1'b1; alloc_addr = 5'd9; we_a = 1'b1; wa_a = 5'd9; wd_a = 64'h9999; raddr[2] = 5'd9;
    cycle();
    set_idle();
    #1;
    check_eq("aw_busy", 64'(rbusy_byp[2]), 64'h1);
    check_eq("aw_data", rdata_nob[2], 64'h9999);
    cycle();

    // FS clean alone clears; clean together with a write stays dirty.
    fs_clean = 1'b1;
    cycle();
    set_idle();
    #1 check_eq("fs_cleaned", 64'(dirty_byp), 64'h0);
    cycle();
    fs_clean = 1'b1; we_a = 1'b1; wa_a = 5'd1; wd_a = 64'h5;
    cycle();
    set_idle();
    #1 check_eq("fs_clean_vs_write", 64'(dirty_byp), 64'h1);
    cycle();

    // Reset between alloc and writeback.
    alloc = 1'b1; alloc_addr = 5'd12;
    raddr[0] = 5'd12; raddr[1] = 5'd5; raddr[2] = 5'd9;
    cycle();
    set_idle();
    #1 check_eq("pre_rst_busy", 64'(rbusy_byp[0]), 64'h1);
    do_reset();
    cycle();

    // Random traffic over a small address window to force collisions.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      for (int k = 0; k < NRP; k++) raddr[k] = 5'($urandom_range(0, 7));
      alloc      = 1'($urandom_range(0, 3) == 0);
      alloc_addr = 5'($urandom_range(0, 7));
      we_a       = 1'($urandom_range(0, 2) == 0);
      wa_a       = 5'($urandom_range(0, 7));
      wd_a       = {$urandom, $urandom};
      ws_a       = 1'($urandom_range(0, 1));
      we_b       = 1'($urandom_range(0, 2) == 0);
      wa_b       = 5'($urandom_range(0, 7));
      wd_b       = {$urandom, $urandom};
      ws_b       = 1'($urandom_range(0, 1));
      fs_clean   = 1'($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
